// File: rtl/carry_skip_pkg.sv
// Shared constants and types for the 32-bit carry-skip adder.
// Latency: none (declarations only); backpressure: not applicable.
package carry_skip_pkg;
    localparam int CS_WIDTH = 32;
    localparam int CS_BLK   = 4;
    localparam int CS_NBLK  = CS_WIDTH / CS_BLK;

    typedef logic [CS_WIDTH-1:0] cs_word_t;
endpackage

// File: rtl/carry_skip_block4.sv
// One 4-bit ripple block with a skip mux on its carry-out.
// Latency: combinational; backpressure: none.
module carry_skip_block4
    import carry_skip_pkg::*;
#(
    parameter int BLK = CS_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);
    logic [BLK-1:0] w_p;
    logic [BLK-1:0] w_g;
    logic [BLK:0]   w_c;
    logic           w_blk_p;

    assign w_p    = a ^ b;
    assign w_g    = a & b;
    assign w_c[0] = cin;

    for (genvar i = 0; i < BLK; i++) begin : g_ripple
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign sum     = w_p ^ w_c[BLK-1:0];
    assign w_blk_p = &w_p;

    // Kept as a distinct mux so the bypass path stays off the ripple chain.
    assign cout = w_blk_p ? cin : w_c[BLK];
endmodule

// File: rtl/carry_skip_32.sv
// 32-bit carry-skip adder, sum and carry-out registered on clk.
// Latency: 1 cycle; backpressure: none, accepts a new operand set every cycle.
module carry_skip_32
    import carry_skip_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int BLK   = CS_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int NBLK = WIDTH / BLK;

    logic [NBLK:0]    w_c;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    assign w_c[0] = ci;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        carry_skip_block4 #(
            .BLK (BLK)
        ) u_blk (
            .a    (a[k*BLK +: BLK]),
            .b    (b[k*BLK +: BLK]),
            .cin  (w_c[k]),
            .sum  (w_sum[k*BLK +: BLK]),
            .cout (w_c[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else begin
            r_s  <= w_sum;
            r_co <= w_c[NBLK];
        end
    end

    assign s  = r_s;
    assign co = r_co;
endmodule

// File: tb/tb_carry_skip_32.sv
// Bench for carry_skip_32: directed literal vectors plus random traffic against an arithmetic model.
module tb_carry_skip_32;
    import carry_skip_pkg::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    cs_word_t a   = 32'h1234_5678;
    cs_word_t b   = 32'h9ABC_DEF0;
    logic     ci  = 1'b1;
    cs_word_t s;
    logic     co;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q   = '0;
    logic        exp_vld = 1'b0;

    carry_skip_32 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .ci  (ci),
        .s   (s),
        .co  (co)
    );

    always #5 clk = ~clk;

    // Reference: what the registers must hold after each edge, from plain addition.
    always @(posedge clk) begin
        exp_q   <= rst ? 33'd0 : ({1'b0, a} + {1'b0, b} + {32'd0, ci});
        exp_vld <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_vld) begin
            checks++;
            if ({co, s} !== exp_q) begin
                errors++;
                $display("FAIL model_cmp t=%0t got co=%0b s=%h expected co=%0b s=%h",
                         $time, co, s, exp_q[32], exp_q[31:0]);
            end
        end
    end

    task automatic check_lit(input string name, input logic [32:0] want);
        checks++;
        if ({co, s} !== want) begin
            errors++;
            $display("FAIL %s got co=%0b s=%h expected co=%0b s=%h",
                     name, co, s, want[32], want[31:0]);
        end
    endtask

    localparam int NV = 13;
    cs_word_t    va [NV];
    cs_word_t    vb [NV];
    logic        vc [NV];
    logic [32:0] ve [NV];

    initial begin
        va = '{32'd5, 32'd37, 32'd125, 32'd63, 32'd122, 32'd245, 32'd3, 32'd100, 32'd127,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_0F0F};
        vb = '{32'd10, 32'd48, 32'd110, 32'd211, 32'd11, 32'd2, 32'd90, 32'd200, 32'd127,
               32'h0, 32'h0, 32'h8000_0000, 32'h00F0_F0F1};
        vc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0};
        ve = '{33'd16, 33'd85, 33'd236, 33'd274, 33'd134, 33'd247, 33'd94, 33'd300, 33'd255,
               33'h1_0000_0000, 33'h0_FFFF_FFFF, 33'h1_0000_0000, 33'h0_1000_0000};

        // Reset held two edges with nonzero operands on the inputs.
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_zero", 33'd0);

        // Directed vectors, one per cycle; each result read one edge later.
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) check_lit($sformatf("vec%0d", i - 1), ve[i-1]);
            if (i < NV) begin
                rst = 1'b0;
                a   = va[i];
                b   = vb[i];
                ci  = vc[i];
            end
            @(posedge clk);
            #1;
        end

        // Back-to-back random traffic with one reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5001) begin
                check_lit("mid_reset_zero", 33'd0);
                rst = 1'b0;
            end
            if (i == 5000) rst = 1'b1;
            a  = $urandom;
            b  = (i % 16 == 3) ? ~a : $urandom;
            ci = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
